mac_seq: RTL and testbench

Sequencer for the 16-lane signed 8-bit MAC (`mac`: `pixelsIn[127:0]`, `weightsIn[127:0]` → `sumOut[19:0]`).
- Deserialises pixel and weight bytes from an 8-bit streaming input into the MAC operand registers.
- Waits out the MAC latency, then accumulates each chunk's dot product.
- Covers up to 16 chunks, i.e. a 256-input neuron.
- Emits the neuron result, with optional ReLU, through a valid/ready handshake.
- Sits between the chip I/O byte stream and the `mac` instance.

---
 rtl/mac_seq.sv | 127 ++++++++++++
 tb/tb_mac_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Byte-stream sequencer for the 16-lane signed 8-bit MAC: loads operands, waits out
// the MAC latency, accumulates up to 16 chunks and hands the neuron result out.
module mac_seq #(
    parameter int MAC_LAT = 1,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       n_chunks,
    input  logic             relu_en,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     pixelsIn,
    output logic [127:0]     weightsIn,
    input  logic [19:0]      sumIn,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int WCW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t                   state, state_next;
    logic [4:0]               byte_cnt;
    logic [3:0]               chunk_idx;
    logic [3:0]               n_lat;
    logic                     relu_lat;
    logic [WCW-1:0]           wait_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     xfer;
    logic                     last_chunk;

    assign xfer       = in_valid && (state == LOAD);
    // n_lat == 0 wraps to 15 here, which is exactly the 16-chunk encoding
    assign last_chunk = (chunk_idx == (n_lat - 4'd1));
    assign acc_sum    = acc + ACC_W'($signed(sumIn));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (xfer && (byte_cnt == 5'd31)) state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) state_next = last_chunk ? DONE : LOAD;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            chunk_idx <= '0;
            n_lat     <= '0;
            relu_lat  <= 1'b0;
            wait_cnt  <= '0;
            acc       <= '0;
            res_data  <= '0;
            pixelsIn  <= '0;
            weightsIn <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        chunk_idx <= '0;
                        byte_cnt  <= '0;
                        n_lat     <= n_chunks;
                        relu_lat  <= relu_en;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (!byte_cnt[4]) begin
                            pixelsIn[{byte_cnt[3:0], 3'b000} +: 8] <= in_data;
                        end else begin
                            weightsIn[{byte_cnt[3:0], 3'b000} +: 8] <= in_data;
                        end
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt == 5'd31) wait_cnt <= WCW'(MAC_LAT);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        acc <= acc_sum;
                        if (last_chunk) begin
                            res_data <= (relu_lat && acc_sum[ACC_W-1]) ? '0 : acc_sum;
                        end else begin
                            chunk_idx <= chunk_idx + 4'd1;
                            byte_cnt  <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: behavioural MAC model, scoreboard of expected
// neuron results, one task per scenario.
module tb_mac_seq;

    localparam int MAC_LAT = 1;
    localparam int ACC_W   = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       n_chunks;
    logic             relu_en;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     pixels;
    logic [127:0]     weights;
    logic [19:0]      sum_in;
    logic [ACC_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int last_gap;
    int last_lat;
    logic [ACC_W-1:0] exp_q[$];
    logic [7:0]       stim [0:511];

    mac_seq #(.MAC_LAT(MAC_LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_chunks(n_chunks),
        .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pixelsIn(pixels), .weightsIn(weights),
        .sumIn(sum_in), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // one-stage registered MAC, matching MAC_LAT = 1
    function automatic logic [19:0] dot(input logic [127:0] p, input logic [127:0] w);
        int s = 0;
        for (int k = 0; k < 16; k++)
            s += int'($signed(p[8*k +: 8])) * int'($signed(w[8*k +: 8]));
        return 20'(s);
    endfunction

    always_ff @(posedge clk) sum_in <= dot(pixels, weights);

    function automatic logic [ACC_W-1:0] model(input int n, input bit relu);
        int acc = 0;
        for (int c = 0; c < n; c++)
            for (int k = 0; k < 16; k++)
                acc += int'($signed(stim[c*32+k])) * int'($signed(stim[c*32+16+k]));
        if (relu && acc < 0) acc = 0;
        return ACC_W'(acc);
    endfunction

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, required handshake never seen", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 512; i++) stim[i] = 8'h00;
    endtask

    task automatic do_start(input logic [3:0] n, input bit relu);
        start = 1'b1; n_chunks = n; relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        bit ok = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_data = b;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!ok) abort_run("byte_accept");
        in_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int cnt;
        bit seen;
        logic [127:0] ep, ew;
        for (int c = 0; c < n; c++) begin
            for (int b = 0; b < 32; b++) send_byte(stim[c*32+b], gaps);
            cnt = 0; seen = 0;
            if (c != n - 1) begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (in_ready) seen = 1; else cnt++;
                end
                if (!seen) abort_run("chunk_gap");
                last_gap = cnt;
            end else begin
                // garbage bytes offered while not loading must not reach the operands
                in_valid = 1'b1; in_data = 8'hFF;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (res_valid) seen = 1; else cnt++;
                end
                if (!seen) abort_run("res_valid_rise");
                last_lat = cnt;
                for (int k = 0; k < 16; k++) begin
                    ep[8*k +: 8] = stim[c*32+k];
                    ew[8*k +: 8] = stim[c*32+16+k];
                end
                checks++;
                if (pixels !== ep || weights !== ew) begin
                    errors++;
                    $display("FAIL operands: got %h/%h required %h/%h", pixels, weights, ep, ew);
                end
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic collect(input int hold, input bit b2b);
        logic [ACC_W-1:0] exp, snap;
        if (exp_q.size() == 0) abort_run("scoreboard_empty");
        exp = exp_q.pop_front();
        snap = res_data;
        for (int h = 0; h < hold; h++) begin
            start = (h % 2 == 0);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== snap || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold: got valid=%b data=%h ready=%b busy=%b required 1 %h 0 1",
                         res_valid, res_data, in_ready, busy, snap);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp) begin
            errors++;
            $display("FAIL result: got valid=%b data=%h required 1 %h", res_valid, res_data, exp);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        if (!b2b) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL release: got valid=%b busy=%b required 0 0", res_valid, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_neuron(input logic [3:0] n, input bit relu, input bit gaps,
                              input int hold, input bit b2b, input logic [ACC_W-1:0] expected);
        int nreal = (n == 4'd0) ? 16 : int'(n);
        exp_q.push_back(expected);
        do_start(n, relu);
        feed(nreal, gaps);
        checks++;
        if (last_lat !== MAC_LAT + 1) begin
            errors++;
            $display("FAIL res_latency: got %0d required %0d", last_lat, MAC_LAT + 1);
        end
        collect(hold, b2b);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_data !== '0 || pixels !== '0 || weights !== '0) begin
            errors++;
            $display("FAIL %s: got ready=%b valid=%b busy=%b data=%h pix=%h wts=%h required all 0",
                     name, in_ready, res_valid, busy, res_data, pixels, weights);
        end
    endtask

    task automatic load_single();
        fill_zero();
        stim[0] = 8'h56; stim[16] = 8'h32;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; n_chunks = 0; relu_en = 0;
        in_data = 0; in_valid = 0; res_ready = 0;
        #12;
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        load_single();
        run_neuron(4'd1, 1'b0, 1'b0, 0, 1'b0, 24'h0010CC);
    endtask

    task automatic test_two_chunks();
        fill_zero();
        stim[0] = 8'h12; stim[16] = 8'h34;
        stim[32] = 8'h52; stim[48] = 8'h13;
        run_neuron(4'd2, 1'b0, 1'b0, 0, 1'b0, 24'h0009BE);
        checks++;
        if (last_gap !== MAC_LAT + 1) begin
            errors++;
            $display("FAIL chunk_gap: got %0d required %0d", last_gap, MAC_LAT + 1);
        end
    endtask

    task automatic test_relu();
        fill_zero();
        for (int k = 0; k < 16; k++) begin
            stim[k] = 8'h80; stim[16+k] = 8'h7F;
        end
        run_neuron(4'd1, 1'b0, 1'b0, 0, 1'b0, 24'hFC0800);
        run_neuron(4'd1, 1'b1, 1'b0, 0, 1'b0, 24'h000000);
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 512; i++) stim[i] = 8'h80;
        run_neuron(4'd0, 1'b0, 1'b0, 0, 1'b0, 24'h400000);
    endtask

    task automatic test_backpressure();
        load_single();
        run_neuron(4'd1, 1'b0, 1'b1, 5, 1'b0, 24'h0010CC);
    endtask

    task automatic test_random();
        for (int i = 0; i < 96; i++) stim[i] = 8'($urandom);
        run_neuron(4'd3, 1'b0, 1'b1, 2, 1'b0, model(3, 1'b0));
        run_neuron(4'd3, 1'b1, 1'b0, 0, 1'b0, model(3, 1'b1));
    endtask

    task automatic test_back_to_back();
        fill_zero();
        stim[5] = 8'hF0; stim[21] = 8'h11;
        run_neuron(4'd1, 1'b1, 1'b0, 0, 1'b1, 24'h000000);
        load_single();
        run_neuron(4'd1, 1'b0, 1'b0, 0, 1'b0, 24'h0010CC);
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom_range(1, 255));
        do_start(4'd1, 1'b0);
        for (int b = 0; b < 10; b++) send_byte(stim[b], 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        check_all_zero("reset_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_single();
        run_neuron(4'd1, 1'b0, 1'b0, 0, 1'b0, 24'h0010CC);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_chunks();
        test_relu();
        test_full_depth();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
